imem_ctrl: RTL

Controller sequencing the single-port instruction memory array: clears it after reset, streams a program image into it from a loader interface, then serves core instruction fetches. It arbitrates the one memory port between loader writes and fetch reads and gates core execution via core_run. It sits between the fetch stage/PC logic, the boot loader and the instruction memory array.

---
 rtl/imem_ctrl_pkg.sv | 17 +
 rtl/imem_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: controller states,
// instruction width and the fault-response instruction.
package imem_ctrl_pkg;

    localparam int unsigned INST_W = 32;

    // addi x0,x0,0 -- returned in place of a faulting fetch
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

endpackage

// File: rtl/imem_ctrl.sv
// Sequences the single-port instruction memory: wipe after reset, program load
// from the boot loader, then 1-cycle-latency instruction fetch for the core.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              ld_valid,
    input  logic [INST_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_inst,
    output logic              fetch_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              core_run,
    output logic              load_ovf
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;      // clear counter in CLEAR, write pointer in LOAD
    logic              ovf_q, ovf_d;
    logic              valid_q, err_q, rd_pend_q;
    logic [INST_W-1:0] inst_q;

    logic              fetch_acc;
    logic              fetch_fault;

    assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= BYTE_LIMIT);

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q;
        ld_ready    = 1'b0;
        fetch_ready = 1'b0;
        core_run    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = '0;
        fetch_acc   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // Gated by rst so the port stays quiet while reset is held.
                mem_en = rst;
                mem_we = rst;
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start_load) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    addr_d    = addr_q + 1'b1;
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end else if (addr_q == LAST_ADDR) begin
                        ovf_d   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (start_load) begin
                    // A reload pre-empts any fetch offered in the same cycle.
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end else begin
                    core_run    = 1'b1;
                    fetch_ready = 1'b1;
                    if (fetch_req) begin
                        fetch_acc = 1'b1;
                        if (!fetch_fault) begin
                            mem_en   = 1'b1;
                            mem_addr = fetch_addr[AW+1:2];
                        end
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            valid_q   <= fetch_acc;
            err_q     <= fetch_acc && fetch_fault;
            rd_pend_q <= fetch_acc && !fetch_fault;
            // A fault response wins: the read data returning this cycle is
            // already presented combinationally and needs no capture.
            if (fetch_acc && fetch_fault) begin
                inst_q <= NOP_INST;
            end else if (rd_pend_q) begin
                inst_q <= mem_rdata;
            end
        end
    end

    // Read data is forwarded in its response cycle and held afterwards.
    assign fetch_inst  = rd_pend_q ? mem_rdata : inst_q;
    assign fetch_valid = valid_q;
    assign fetch_err   = err_q;
    assign load_ovf    = ovf_q;

endmodule
